// File: rtl/md_bus_pkg.sv
// Shared definitions for the md_bus_share bus-ownership slice.
package md_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    // Widest source count the slice supports; also sets the forced-select width.
    localparam int MAX_SRC = 8;
    localparam int SEL_W   = 3;

    // True when at least two bits of v are set.
    function automatic logic popcnt_ge2(input logic [MAX_SRC-1:0] v);
        logic seen;
        logic ge2;
        seen = 1'b0;
        ge2  = 1'b0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (v[i]) begin
                ge2  = ge2 | seen;
                seen = 1'b1;
            end
        end
        return ge2;
    endfunction

    // Bit pos of the one-hot decode of idx.
    function automatic logic onehot_bit(input logic [SEL_W-1:0] idx, input int pos);
        return idx == SEL_W'(pos);
    endfunction

endpackage

// File: rtl/md_rr_pick.sv
// Next-owner picker: fixed priority (lowest index) or round-robin after the last owner.
module md_rr_pick
    import md_bus_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int RR   = 0,
    localparam int IW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            vld
);

    // Fixed priority is round-robin starting after the top index, so both share one scan.
    logic [IW-1:0] base;

    // Scan from farthest to nearest candidate so the nearest set request wins.
    always_comb begin
        base = (RR != 0) ? ptr : IW'(NSRC - 1);
        idx  = '0;
        vld  = 1'b0;
        for (int i = NSRC; i >= 1; i--) begin
            int j;
            j = (int'(base) + i) % NSRC;
            if (req[IW'(j)]) begin
                idx = IW'(j);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/md_bus_share.sv
// N-source shared-bus driver: registered ownership, turnaround, per-lane direction,
// test-mode forced routing and a contention monitor.
module md_bus_share
    import md_bus_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int W     = 16,
    parameter int LANES = 2,
    parameter int TURN  = 1,
    parameter int RR    = 0,
    parameter int CNT_W = 8
) (
    input  logic                  MCLK,
    input  logic                  SRES,
    input  logic                  MCLK_e,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*LANES-1:0] lane_req,
    input  logic [NSRC*W-1:0]     src_data,
    input  logic                  force_en,
    input  logic [2:0]            force_sel,
    output logic [W-1:0]          bus_o,
    output logic [W-1:0]          bus_d,
    output logic [NSRC-1:0]       grant,
    output logic                  busy,
    output logic                  contend,
    output logic [CNT_W-1:0]      cont_cnt
);

    localparam int IW              = $clog2(NSRC);
    localparam int LW              = W / LANES;
    localparam logic [1:0] TURN_INIT = 2'(TURN);

    state_e             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [1:0]         turn_q, turn_d;
    logic               contend_q, contend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               repick;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic [SEL_W-1:0]   sel;
    logic               sel_vld;
    logic [LANES-1:0]   lane_on;

    md_rr_pick #(
        .NSRC (NSRC),
        .RR   (RR)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Ownership FSM next state, turnaround countdown and contention monitor.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        turn_d    = turn_q;
        contend_d = contend_q;
        cnt_d     = cnt_q;
        repick    = 1'b0;
        case (state_q)
            ST_IDLE: repick = 1'b1;
            ST_OWN: begin
                if (!req[owner_q]) begin
                    if (TURN > 0) begin
                        state_d = ST_TURN;
                        turn_d  = TURN_INIT;
                    end else begin
                        repick = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (turn_q <= 2'd1) begin
                    repick = 1'b1;
                end else begin
                    turn_d = turn_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (repick) begin
            if (pick_vld) begin
                state_d = ST_OWN;
                owner_d = pick_idx;
                ptr_d   = pick_idx;
            end else begin
                state_d = ST_IDLE;
            end
        end
        if (popcnt_ge2(MAX_SRC'(req))) begin
            contend_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers advance only on enabled clock edges; reset releases the bus at once.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            turn_q    <= '0;
            contend_q <= 1'b0;
            cnt_q     <= '0;
        end else if (MCLK_e) begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            turn_q    <= turn_d;
            contend_q <= contend_d;
            cnt_q     <= cnt_d;
        end
    end

    // Pad drive: the forced source overrides the registered owner; out-of-range means released.
    always_comb begin
        if (force_en) begin
            sel     = force_sel;
            sel_vld = (int'(force_sel) < NSRC);
        end else begin
            sel     = SEL_W'(owner_q);
            sel_vld = (state_q == ST_OWN);
        end
        bus_o   = '0;
        grant   = '0;
        lane_on = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_vld && onehot_bit(sel, i)) begin
                bus_o    = src_data[i*W +: W];
                lane_on  = lane_req[i*LANES +: LANES];
                grant[i] = 1'b1;
            end
        end
        bus_d = '1;
        for (int k = 0; k < LANES; k++) begin
            bus_d[k*LW +: LW] = {LW{~lane_on[k]}};
        end
    end

    assign busy     = (state_q == ST_OWN);
    assign contend  = contend_q;
    assign cont_cnt = cnt_q;

endmodule
